ram_wb_arb2: RTL

- Two-master Wishbone B3 arbiter sharing one registered-feedback RAM slave (128 KB on-chip RAM) between the CPU instruction bus (m0) and the data bus/debug (m1).
- Grant is held for the whole bus cycle (`cyc` high), so incrementing/wrap bursts and classic cycles pass to the slave unbroken.
- Round-robin fairness.
- Sits between the master-side bus and the RAM slave in the SoC top.

---
 rtl/ram_wb_pkg.sv | 33 +++
 rtl/ram_wb_arb_rr.sv | 58 +++++
 rtl/ram_wb_arb2.sv | 126 ++++++++++++
 3 files changed

// File: rtl/ram_wb_pkg.sv
// Shared definitions for the two-master RAM Wishbone arbiter: Wishbone B3
// cycle/burst type codes and the arbiter state encoding.
package ram_wb_pkg;

    // Wishbone B3 cycle type identifiers
    typedef enum logic [2:0] {
        CTI_CLASSIC = 3'b000,
        CTI_CONST   = 3'b001,
        CTI_INCR    = 3'b010,
        CTI_EOB     = 3'b111
    } cti_e;

    // Wishbone B3 burst type extensions
    typedef enum logic [1:0] {
        BTE_LINEAR = 2'b00,
        BTE_WRAP4  = 2'b01,
        BTE_WRAP8  = 2'b10,
        BTE_WRAP16 = 2'b11
    } bte_e;

    // Arbiter state: idle, or bus granted to master 0 / master 1
    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_G0   = 2'b01,
        ARB_G1   = 2'b10
    } arb_state_e;

    // One-hot grant vector for a given arbiter state
    function automatic logic [1:0] state2gnt(input arb_state_e s);
        return {s == ARB_G1, s == ARB_G0};
    endfunction

endpackage

// File: rtl/ram_wb_arb_rr.sv
// Round-robin grant FSM for two Wishbone masters. A grant is held for as
// long as the owner keeps cyc high; on release the other master takes over
// on the next edge with no idle bubble. 'last' remembers the most recent
// owner so simultaneous requests from IDLE alternate. 'rel' forces the
// current owner off the bus (watchdog timeout).
module ram_wb_arb_rr
    import ram_wb_pkg::*;
(
    input  logic       wb_clk_i,
    input  logic       wb_rst_n_i,
    input  logic [1:0] req,
    input  logic       rel,
    output arb_state_e state,
    output logic [1:0] gnt
);

    arb_state_e state_n;
    logic       last;     // 1: m1 owned the bus most recently, so m0 wins a tie
    logic       last_n;

    // State and last-owner registers; reset leaves m0 as the tie winner
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state <= ARB_IDLE;
            last  <= 1'b1;
        end else begin
            state <= state_n;
            last  <= last_n;
        end
    end

    // Next-state: grant on request, hold while cyc, hand over or go idle on release
    always_comb begin
        state_n = state;
        last_n  = last;
        case (state)
            ARB_IDLE: begin
                if (req == 2'b11)  state_n = last ? ARB_G0 : ARB_G1;
                else if (req[0])   state_n = ARB_G0;
                else if (req[1])   state_n = ARB_G1;
            end
            ARB_G0: begin
                if (!req[0] || rel) state_n = req[1] ? ARB_G1 : ARB_IDLE;
            end
            ARB_G1: begin
                if (!req[1] || rel) state_n = req[0] ? ARB_G0 : ARB_IDLE;
            end
            default: state_n = ARB_IDLE;
        endcase
        if (state_n != state) begin
            if (state_n == ARB_G0)      last_n = 1'b0;
            else if (state_n == ARB_G1) last_n = 1'b1;
        end
    end

    assign gnt = state2gnt(state);

endmodule

// File: rtl/ram_wb_arb2.sv
// Two-master Wishbone B3 arbiter in front of the on-chip RAM slave.
// m0 = CPU instruction bus, m1 = data bus / debug. Grant is held for a whole
// bus cycle so bursts reach the slave unbroken; ties alternate round-robin.
// Optional macro RAM_WB_ARB_WATCHDOG_EN adds a stall watchdog that errors
// out a master whose strobe goes unterminated for TO_CYCLES cycles.
module ram_wb_arb2
    import ram_wb_pkg::*;
#(
    parameter int dw        = 32,
    parameter int aw        = 32,
    parameter int TO_CYCLES = 256,
    parameter int TO_W      = 9
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_n_i,
    // master 0
    input  logic [aw-1:0] m0_adr_i,
    input  logic [dw-1:0] m0_dat_i,
    input  logic [3:0]    m0_sel_i,
    input  logic [2:0]    m0_cti_i,
    input  logic [1:0]    m0_bte_i,
    input  logic          m0_cyc_i,
    input  logic          m0_stb_i,
    input  logic          m0_we_i,
    output logic [dw-1:0] m0_dat_o,
    output logic          m0_ack_o,
    output logic          m0_err_o,
    output logic          m0_rty_o,
    // master 1
    input  logic [aw-1:0] m1_adr_i,
    input  logic [dw-1:0] m1_dat_i,
    input  logic [3:0]    m1_sel_i,
    input  logic [2:0]    m1_cti_i,
    input  logic [1:0]    m1_bte_i,
    input  logic          m1_cyc_i,
    input  logic          m1_stb_i,
    input  logic          m1_we_i,
    output logic [dw-1:0] m1_dat_o,
    output logic          m1_ack_o,
    output logic          m1_err_o,
    output logic          m1_rty_o,
    // slave
    output logic [aw-1:0] s_adr_o,
    output logic [dw-1:0] s_dat_o,
    output logic [3:0]    s_sel_o,
    output logic [2:0]    s_cti_o,
    output logic [1:0]    s_bte_o,
    output logic          s_cyc_o,
    output logic          s_stb_o,
    output logic          s_we_o,
    input  logic [dw-1:0] s_dat_i,
    input  logic          s_ack_i,
    input  logic          s_err_i,
    input  logic          s_rty_i,
    // debug / perf
    output logic [1:0]    gnt_o
);

    // The watchdog counter must be able to hold TO_CYCLES
    if ((1 << TO_W) <= TO_CYCLES) begin : g_bad_to_w
        $error("ram_wb_arb2: TO_W too narrow for TO_CYCLES");
    end

    arb_state_e state;
    logic [1:0] gnt;
    logic       sel_m1;   // data-path select; IDLE routes m0 through
    logic       cyc_g;    // cyc of the granted master (0 in IDLE)
    logic       stb_g;    // stb of the granted master (0 in IDLE)
    logic       term;
    logic       wd_hit;   // watchdog fires this cycle

    ram_wb_arb_rr u_rr (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_n_i (wb_rst_n_i),
        .req        ({m1_cyc_i, m0_cyc_i}),
        .rel        (wd_hit),
        .state      (state),
        .gnt        (gnt)
    );

    assign sel_m1 = (state == ARB_G1);
    assign cyc_g  = (gnt[0] & m0_cyc_i) | (gnt[1] & m1_cyc_i);
    assign stb_g  = (gnt[0] & m0_stb_i) | (gnt[1] & m1_stb_i);
    assign term   = s_ack_i | s_err_i | s_rty_i;

`ifdef RAM_WB_ARB_WATCHDOG_EN
    logic [TO_W-1:0] wd_cnt;

    // Fires on the TO_CYCLES-th consecutive unterminated strobe cycle
    assign wd_hit = stb_g & ~term & (wd_cnt == TO_W'(TO_CYCLES - 1));

    // Stall counter: runs on unterminated strobes, cleared by termination,
    // by the owner releasing cyc (grant change), in IDLE, and after firing
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i)                   wd_cnt <= '0;
        else if (!cyc_g || term || wd_hit) wd_cnt <= '0;
        else if (stb_g)                    wd_cnt <= wd_cnt + 1'b1;
    end
`else
    assign wd_hit = 1'b0;
`endif

    // Request path: data follows the grant, controls are killed in IDLE
    // and during a watchdog hit so the slave sees the cycle end
    assign s_adr_o = sel_m1 ? m1_adr_i : m0_adr_i;
    assign s_dat_o = sel_m1 ? m1_dat_i : m0_dat_i;
    assign s_sel_o = sel_m1 ? m1_sel_i : m0_sel_i;
    assign s_cti_o = sel_m1 ? m1_cti_i : m0_cti_i;
    assign s_bte_o = sel_m1 ? m1_bte_i : m0_bte_i;
    assign s_we_o  = sel_m1 ? m1_we_i  : m0_we_i;
    assign s_cyc_o = cyc_g & ~wd_hit;
    assign s_stb_o = stb_g & ~wd_hit;

    // Return path: terminations only to the owner, read data broadcast
    assign m0_ack_o = gnt[0] & s_ack_i;
    assign m0_err_o = gnt[0] & (s_err_i | wd_hit);
    assign m0_rty_o = gnt[0] & s_rty_i;
    assign m1_ack_o = gnt[1] & s_ack_i;
    assign m1_err_o = gnt[1] & (s_err_i | wd_hit);
    assign m1_rty_o = gnt[1] & s_rty_i;
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    assign gnt_o = gnt;

endmodule
